// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
// Holds the channel FSM encoding and counter sizing helper.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_t;

    localparam int DEF_N_BTN        = 3;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_DEBOUNCE_CYC = 16;
    localparam int DEF_REPEAT_DELAY = 64;
    localparam int DEF_REPEAT_RATE  = 16;

    // Bits needed to hold counts 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchronizer, debounce FSM and auto-repeat.
// All outputs are registered.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic pulse,
    output logic rel
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                       : REPEAT_RATE;
    localparam int DW = cnt_w(DEBOUNCE_CYC);
    localparam int RW = cnt_w(RMAX);

    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_LATER = RW'(REPEAT_RATE - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    btn_state_t    state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          later, later_nxt;
    logic          level_nxt, pulse_nxt, rel_nxt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            state <= IDLE;
            dcnt  <= '0;
            rcnt  <= '0;
            later <= 1'b0;
            level <= 1'b0;
            pulse <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw};
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            rcnt  <= rcnt_nxt;
            later <= later_nxt;
            level <= level_nxt;
            pulse <= pulse_nxt;
            rel   <= rel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        rcnt_nxt  = rcnt;
        later_nxt = later;
        level_nxt = level;
        pulse_nxt = 1'b0;
        rel_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = PRESS_CHK;
                    dcnt_nxt  = '0;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (dcnt == D_LAST) begin
                    state_nxt = HELD;
                    level_nxt = 1'b1;
                    pulse_nxt = 1'b1;
                    rcnt_nxt  = '0;
                    later_nxt = 1'b0;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            // later selects the short inter-repeat period after the first
            HELD: begin
                if (!s) begin
                    state_nxt = REL_CHK;
                    dcnt_nxt  = '0;
                end else if (!repeat_en) begin
                    rcnt_nxt  = '0;
                    later_nxt = 1'b0;
                end else if (rcnt == (later ? R_LATER : R_FIRST)) begin
                    pulse_nxt = 1'b1;
                    rcnt_nxt  = '0;
                    later_nxt = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            REL_CHK: begin
                if (s) begin
                    state_nxt = HELD;
                    rcnt_nxt  = '0;
                    later_nxt = 1'b0;
                end else if (dcnt == D_LAST) begin
                    state_nxt = IDLE;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounced levels, press/repeat pulses and release pulses
// for N_BTN independent raw push-buttons.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw      (btn_raw[i]),
            .repeat_en(repeat_en[i]),
            .level    (btn_level[i]),
            .pulse    (btn_pulse[i]),
            .rel      (btn_release[i])
        );
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the digit-entry / GCD datapath.
- Takes raw mechanical push-button levels (add, next and similar) and outputs clean, debounced levels and single-cycle press pulses.
- The downstream stage's own edge detectors see one clean rising edge per physical press.
- Optional per-button auto-repeat: holding "add" steps the selected digit at a fixed rate.

Parameters:
- N_BTN, 3: number of independent button channels.
- SYNC_STAGES, 2: synchronizer flip-flop depth per channel (minimum 2).
- DEBOUNCE_CYC, 16: consecutive stable cycles needed to accept a press or release (minimum 2).
- REPEAT_DELAY, 64: cycles from the press pulse to the first repeat pulse (minimum 2).
- REPEAT_RATE, 16: cycles between later repeat pulses (minimum 2).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset; asynchronous assert, active-low.
- btn_raw, input, N_BTN: asynchronous raw button levels, active-high.
- repeat_en, input, N_BTN: per-channel auto-repeat enable, sampled every cycle.
- btn_level, output, N_BTN: debounced button level.
- btn_pulse, output, N_BTN: one-cycle pulse on an accepted press and on each repeat.
- btn_release, output, N_BTN: one-cycle pulse on an accepted release.

Behaviour:
- Reset
  - rst_n is asynchronous, active-low; clock is clk.
  - Every synchronizer flop, counter and output resets to 0; every channel FSM resets to IDLE.
  - Reset mid-press: the channel returns to IDLE; no pulse is emitted on reset exit.
  - A button already held at reset exit is re-debounced and gives a normal press pulse.
- Channels are fully independent; simultaneous activity on several channels is legal and does not interact.
- Synchronizer: btn_raw[i] passes through SYNC_STAGES flops, giving s[i]. The FSM sees only s[i].
- Per-channel FSM, with debounce counter dcnt and repeat counter rcnt:
  - IDLE (level 0): if s=1, go to PRESS_CHK with dcnt=0.
  - PRESS_CHK:
    - if s=0, go to IDLE (glitch rejected, no output);
    - else if dcnt==DEBOUNCE_CYC-1, go to HELD, set level=1, pulse=1 for one cycle, rcnt=0;
    - else dcnt+1.
  - HELD (level 1):
    - if s=0, go to REL_CHK with dcnt=0;
    - else if repeat_en=0, rcnt=0;
    - else rcnt+1. When rcnt reaches REPEAT_DELAY-1 (first repeat) or REPEAT_RATE-1 (later repeats), pulse=1 for one cycle and rcnt=0.
    - A first/later phase flag selects which limit applies. The flag clears on entry to HELD from PRESS_CHK and whenever repeat_en=0.
  - REL_CHK (level stays 1):
    - if s=1, go to HELD; rcnt and the phase flag restart from the first-repeat phase;
    - else if dcnt==DEBOUNCE_CYC-1, go to IDLE, set level=0, release=1 for one cycle;
    - else dcnt+1.
    - No repeat pulses are emitted while in REL_CHK.
- Latency
  - Press pulse and btn_level rise occur at the clock edge SYNC_STAGES+DEBOUNCE_CYC edges after the edge that first samples btn_raw=1, provided raw stays high.
  - Release pulse and btn_level fall are symmetric.
- Outputs are all registered; btn_pulse and btn_release are never both high on one channel.
- Counter widths are $clog2 of the largest count each counter needs; there is no wrap-around, because each counter is cleared at its terminal value.
- Raw bounce shorter than DEBOUNCE_CYC cycles in any state yields no output change.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, PRESS_CHK, HELD, REL_CHK) as a 2-bit typedef;
  - default timing constants;
  - a counter-width helper function.
- One natural sub-module, debounce_channel, holds the synchronizer, FSM and both counters for one bit.
- The top level instantiates N_BTN copies with a generate loop and concatenates the outputs.

Test Plan:
- Bench parameters: DEBOUNCE_CYC=4, REPEAT_DELAY=8, REPEAT_RATE=3, SYNC_STAGES=2.
- Clean press on btn_raw[0] sampled at edge k → btn_pulse[0] high for exactly the cycle after edge k+6; btn_level[0]=1 from then on; other channels stay 0.
- Bounce: raw[1] toggles 1,0,1,0 every cycle, then settles at 1 → exactly one btn_pulse[1], 6 edges after the settle sample; no pulse during the bounce.
- Auto-repeat: hold raw[0] with repeat_en[0]=1 → press pulse at P, repeats at P+8, P+11, P+14. Dropping repeat_en for 1 cycle at P+12 → next repeat at P+12+1+8.
- Release: drop raw[0] after it is held → btn_release[0] one cycle, 6 edges after the falling sample; btn_level[0]=0. A 2-cycle low glitch while held → no release and level stays 1.
- Reset mid-PRESS_CHK (rst_n low for 1 cycle, raw held high) → all outputs 0 immediately; after release of reset, pulse 6 edges after the first sample.
- Channels 0 and 2 pressed on the same cycle → both pulses on the same cycle; channel 1 unaffected.
